// File: rtl/controle_movimento.sv
// controle_movimento: button conditioning, animation step timing and frame/digit
// position tracking for the dog-animation segment datapath.
//  - botao is synchronized, debounced and classified into short/long presses.
//  - A small FSM (IDLE/RUN/PAUSE) gates a tick counter whose period is selected
//    by velocidade; every period end produces a one-cycle passo pulse.
//  - passo advances frame, and frame wrap advances the digit position.
// All outputs come straight from flops; passo is computed one cycle ahead so it
// can be registered while still honouring same-cycle press/wrap collisions.
module controle_movimento #(
  parameter int unsigned DEB_CYC   = 50000,
  parameter int unsigned LONG_CYC  = 100000000,
  parameter int unsigned TICK_BASE = 12500000,
  parameter int unsigned NFRAMES   = 6,
  parameter int unsigned NDIG      = 4
) (
  input  logic                       clkd,
  input  logic                       reset,
  input  logic                       botao,
  input  logic [1:0]                 velocidade,
  output logic                       passo,
  output logic [$clog2(NFRAMES)-1:0] frame,
  output logic [$clog2(NDIG)-1:0]    posicao,
  output logic [NDIG-1:0]            dig_sel,
  output logic [1:0]                 estado
);

  localparam int FW   = $clog2(NFRAMES);
  localparam int PW   = $clog2(NDIG);
  localparam int TW   = $clog2(4 * TICK_BASE + 1);
  localparam int DW   = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int HW   = $clog2(LONG_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_t;

  // Step period in cycles for a given speed selection (3 is fastest).
  function automatic logic [TW-1:0] period_of(input logic [1:0] v);
    logic [TW-1:0] p;
    case (v)
      2'd0:    p = TW'(4 * TICK_BASE);
      2'd1:    p = TW'(3 * TICK_BASE);
      2'd2:    p = TW'(2 * TICK_BASE);
      2'd3:    p = TW'(TICK_BASE);
      default: p = TW'(TICK_BASE);
    endcase
    return p;
  endfunction

  // Button path state
  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [HW-1:0] hold_q, hold_d;

  // Sequencer state
  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [TW-1:0] per_q, per_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [PW-1:0] pos_q, pos_d;
  logic          passo_q, passo_d;
  logic [NDIG-1:0] dig_sel_q, dig_sel_d;

  // Decoded events
  logic deb_diff_s, deb_flip_s;
  logic long_ev_s, short_ev_s, long_nxt_s, wrap_s;

  // Debounce filter, hold counter and press classification.
  always_comb begin
    deb_diff_s = (sync2_q != deb_q);
    deb_flip_s = deb_diff_s && (deb_cnt_q == DW'(DEB_CYC - 1));
    if (deb_flip_s) begin
      deb_cnt_d = '0;
      deb_d     = sync2_q;
    end else if (deb_diff_s) begin
      deb_cnt_d = deb_cnt_q + DW'(1);
      deb_d     = deb_q;
    end else begin
      deb_cnt_d = '0;
      deb_d     = deb_q;
    end

    if (!deb_q) begin
      hold_d = '0;
    end else if (hold_q == HW'(LONG_CYC)) begin
      hold_d = hold_q;
    end else begin
      hold_d = hold_q + HW'(1);
    end

    // Long fires in the cycle the hold counter steps onto LONG_CYC.
    long_ev_s  = deb_q && (hold_q == HW'(LONG_CYC - 1));
    // Short fires in the cycle the debounced level is about to drop.
    short_ev_s = deb_q && deb_flip_s && (hold_q < HW'(LONG_CYC)) && !long_ev_s;
    // Same long-event decode applied to next-cycle values, used for passo lookahead.
    long_nxt_s = deb_d && (hold_d == HW'(LONG_CYC - 1));
  end

  // Sequencer next state: FSM, tick counter, frame/position and registered outputs.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    per_d   = per_q;
    wrap_s  = (tick_q == (per_q - TW'(1)));

    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        if (long_ev_s) begin
          state_d = S_IDLE;
        end else if (short_ev_s) begin
          state_d = S_RUN;
          per_d   = period_of(velocidade);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (long_ev_s) begin
          state_d = S_IDLE;
          tick_d  = '0;
        end else begin
          if (wrap_s) begin
            tick_d = '0;
            per_d  = period_of(velocidade);
          end else begin
            tick_d = tick_q + TW'(1);
          end
          if (short_ev_s) begin
            state_d = S_PAUSE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_PAUSE: begin
        if (long_ev_s) begin
          state_d = S_IDLE;
          tick_d  = '0;
        end else if (short_ev_s) begin
          state_d = S_RUN;
        end else begin
          state_d = S_PAUSE;
        end
      end
      default: begin
        state_d = S_IDLE;
        tick_d  = '0;
      end
    endcase

    // Frame/position follow the passo pulse currently on the output.
    if (state_d == S_IDLE) begin
      frame_d = '0;
      pos_d   = '0;
    end else if (passo_q) begin
      if (frame_q == FW'(NFRAMES - 1)) begin
        frame_d = '0;
        if (pos_q == PW'(NDIG - 1)) begin
          pos_d = '0;
        end else begin
          pos_d = pos_q + PW'(1);
        end
      end else begin
        frame_d = frame_q + FW'(1);
        pos_d   = pos_q;
      end
    end else begin
      frame_d = frame_q;
      pos_d   = pos_q;
    end

    // passo is high in the RUN cycle where the tick counter sits at P-1,
    // unless a long press lands on that same cycle.
    passo_d = (state_d == S_RUN) && (tick_d == (per_d - TW'(1))) && !long_nxt_s;

    if (state_d == S_IDLE) begin
      dig_sel_d = '0;
    end else begin
      dig_sel_d = NDIG'(1) << pos_d;
    end
  end

  // Button synchronizer, debounce and hold registers.
  always_ff @(posedge clkd or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
      hold_q    <= '0;
    end else begin
      sync1_q   <= botao;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
      hold_q    <= hold_d;
    end
  end

  // FSM, tick counter and registered outputs.
  always_ff @(posedge clkd or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      per_q     <= '0;
      frame_q   <= '0;
      pos_q     <= '0;
      passo_q   <= 1'b0;
      dig_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      per_q     <= per_d;
      frame_q   <= frame_d;
      pos_q     <= pos_d;
      passo_q   <= passo_d;
      dig_sel_q <= dig_sel_d;
    end
  end

  assign passo   = passo_q;
  assign frame   = frame_q;
  assign posicao = pos_q;
  assign dig_sel = dig_sel_q;
  assign estado  = state_q;

endmodule

// File: tb/tb_controle_movimento.sv
// Directed bench for controle_movimento with small timing parameters.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// A button edge applied after edge S becomes a debounced edge at S+4, so a
// release applied after edge F yields its event in the cycle (F+3, F+4).
module tb_controle_movimento;

  logic       clkd = 1'b0;
  logic       reset;
  logic       botao;
  logic [1:0] velocidade;
  logic       passo;
  logic [2:0] frame;
  logic [1:0] posicao;
  logic [3:0] dig_sel;
  logic [1:0] estado;

  int n_cmp = 0;
  int n_bad = 0;

  controle_movimento #(
    .DEB_CYC  (2),
    .LONG_CYC (20),
    .TICK_BASE(4),
    .NFRAMES  (6),
    .NDIG     (4)
  ) dut (
    .clkd      (clkd),
    .reset     (reset),
    .botao     (botao),
    .velocidade(velocidade),
    .passo     (passo),
    .frame     (frame),
    .posicao   (posicao),
    .dig_sel   (dig_sel),
    .estado    (estado)
  );

  always #5 clkd = ~clkd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clkd);
    #1;
  endtask

  task automatic press(input int h);
    botao = 1'b1;
    repeat (h) step();
    botao = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    botao      = 1'b0;
    velocidade = 2'd3;
    #1 reset = 1'b0;
    #2;
    chk("rst_estado", 32'(estado), 32'd0);
    chk("rst_passo", 32'(passo), 32'd0);
    chk("rst_frame", 32'(frame), 32'd0);
    chk("rst_pos", 32'(posicao), 32'd0);
    chk("rst_dig", 32'(dig_sel), 32'd0);
    step();
    step();
    reset = 1'b1;
    repeat (10) step();
    chk("idle_after_rst", 32'(estado), 32'd0);
    chk("idle_dig", 32'(dig_sel), 32'd0);

    // Single-cycle glitch is filtered out
    press(1);
    repeat (10) step();
    chk("glitch_estado", 32'(estado), 32'd0);

    // Start at fastest speed, 4-cycle period, full frame/position wrap
    velocidade = 2'd3;
    press(5);
    repeat (4) step();
    chk("start_estado", 32'(estado), 32'd1);
    chk("start_dig", 32'(dig_sel), 32'd1);
    chk("start_frame", 32'(frame), 32'd0);
    chk("start_passo", 32'(passo), 32'd0);
    for (int k = 0; k < 24; k++) begin
      for (int c = 1; c <= 4; c++) begin
        step();
        chk("run4_passo", 32'(passo), 32'(c == 3));
      end
      chk("run4_frame", 32'(frame), 32'((k + 1) % 6));
      chk("run4_pos", 32'(posicao), 32'(((k + 1) / 6) % 4));
      chk("run4_dig", 32'(dig_sel), 32'(1 << (((k + 1) / 6) % 4)));
    end

    // Asynchronous reset in the middle of RUN at frame 3
    repeat (12) step();
    chk("pre_rst_frame", 32'(frame), 32'd3);
    step();
    reset = 1'b0;
    #1;
    chk("arst_estado", 32'(estado), 32'd0);
    chk("arst_frame", 32'(frame), 32'd0);
    chk("arst_pos", 32'(posicao), 32'd0);
    chk("arst_dig", 32'(dig_sel), 32'd0);
    chk("arst_passo", 32'(passo), 32'd0);
    #1 reset = 1'b1;
    repeat (10) step();
    chk("post_rst_estado", 32'(estado), 32'd0);
    chk("post_rst_frame", 32'(frame), 32'd0);

    // Slowest speed, then a mid-period switch that applies from the next period
    velocidade = 2'd0;
    press(2);
    repeat (4) step();
    chk("slow_estado", 32'(estado), 32'd1);
    for (int c = 1; c <= 16; c++) begin
      step();
      chk("p16_passo", 32'(passo), 32'(c == 15));
    end
    for (int c = 1; c <= 32; c++) begin
      step();
      if (c == 5) velocidade = 2'd2;
      chk("p16to8_passo", 32'(passo), 32'((c == 15) || (c == 23) || (c == 31)));
    end
    chk("speed_frame", 32'(frame), 32'd4);

    // Long press in RUN (no wrap collision) returns to IDLE
    repeat (2) step();
    botao = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      chk("long_estado", 32'(estado), 32'((c >= 24) ? 0 : 1));
      chk("long_passo", 32'(passo), 32'((c == 5) || (c == 13) || (c == 21)));
      if (c == 23) begin
        chk("long_pre_frame", 32'(frame), 32'd1);
        chk("long_pre_pos", 32'(posicao), 32'd1);
      end
    end
    chk("long_frame", 32'(frame), 32'd0);
    chk("long_pos", 32'(posicao), 32'd0);
    chk("long_dig", 32'(dig_sel), 32'd0);
    botao = 1'b0;
    repeat (10) step();
    chk("long_release_estado", 32'(estado), 32'd0);

    // Pause one cycle after a passo, then resume with the remaining 3 cycles
    velocidade = 2'd3;
    press(2);
    repeat (4) step();
    chk("pr_start_estado", 32'(estado), 32'd1);
    repeat (3) step();
    chk("pr_first_passo", 32'(passo), 32'd1);
    press(2);
    repeat (2) step();
    chk("pr_second_passo", 32'(passo), 32'd1);
    step();
    chk("pr_after_passo", 32'(passo), 32'd0);
    chk("pr_still_run", 32'(estado), 32'd1);
    step();
    chk("pr_pause_estado", 32'(estado), 32'd2);
    chk("pr_pause_frame", 32'(frame), 32'd2);
    chk("pr_pause_passo", 32'(passo), 32'd0);
    for (int c = 1; c <= 10; c++) begin
      step();
      chk("pause_no_passo", 32'(passo), 32'd0);
    end
    chk("pause_hold_estado", 32'(estado), 32'd2);
    chk("pause_hold_frame", 32'(frame), 32'd2);
    botao = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 2) botao = 1'b0;
      chk("resume_estado", 32'(estado), 32'((c >= 6) ? 1 : 2));
      chk("resume_passo", 32'(passo), 32'(c == 8));
    end
    chk("resume_frame", 32'(frame), 32'd3);

    // Short event on a wrap cycle: passo kept, frame advances, then PAUSE
    repeat (2) step();
    press(2);
    repeat (3) step();
    chk("sw_passo", 32'(passo), 32'd1);
    chk("sw_estado", 32'(estado), 32'd1);
    chk("sw_frame", 32'(frame), 32'd4);
    step();
    chk("sw_pause", 32'(estado), 32'd2);
    chk("sw_frame_adv", 32'(frame), 32'd5);
    chk("sw_passo_off", 32'(passo), 32'd0);
    repeat (3) step();
    chk("sw_still_pause", 32'(estado), 32'd2);

    // Long event on a wrap cycle: IDLE wins and passo is suppressed
    botao = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 2) botao = 1'b0;
      chk("lw_resume_estado", 32'(estado), 32'((c >= 6) ? 1 : 2));
    end
    botao = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      step();
      chk("lw_passo", 32'(passo), 32'(((c % 4) == 3) && (c < 23)));
      chk("lw_estado", 32'(estado), 32'((c >= 24) ? 0 : 1));
      if (c == 23) begin
        chk("lw_pre_frame", 32'(frame), 32'd4);
        chk("lw_pre_pos", 32'(posicao), 32'd1);
        chk("lw_pre_dig", 32'(dig_sel), 32'd2);
      end
      if (c == 24) begin
        chk("lw_frame", 32'(frame), 32'd0);
        chk("lw_pos", 32'(posicao), 32'd0);
        chk("lw_dig", 32'(dig_sel), 32'd0);
      end
    end
    botao = 1'b0;
    repeat (10) step();
    chk("lw_release_estado", 32'(estado), 32'd0);
    chk("lw_release_passo", 32'(passo), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
